// File: rtl/pe_link_pkg.sv
// Shared types and constants for the PE link port (stream slot host partner).
package pe_link_pkg;

    localparam int unsigned WORD_W       = 64;
    localparam int unsigned DRAIN_CYCLES = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        PERST,
        DRAIN,
        RUN
    } state_e;

endpackage

// File: rtl/pe_link_if.sv
// PE stream (D/Q) and host valid/ready signals of one PE channel.
interface pe_link_if;
    import pe_link_pkg::*;

    word_t d;
    logic  d_valid;
    logic  d_bp;
    word_t q;
    logic  q_valid;
    logic  q_bp;
    word_t tx_data;
    logic  tx_valid;
    logic  tx_ready;
    word_t rx_data;
    logic  rx_valid;
    logic  rx_ready;

    modport slave (
        output d, d_valid, q_bp, tx_ready, rx_data, rx_valid,
        input  d_bp, q, q_valid, tx_data, tx_valid, rx_ready
    );

    modport master (
        input  d, d_valid, q_bp, tx_ready, rx_data, rx_valid,
        output d_bp, q, q_valid, tx_data, tx_valid, rx_ready
    );

endinterface

// File: rtl/pe_link_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; flush outranks push/pop.
module pe_link_fifo #(
    parameter int unsigned W  = 64,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign count   = wptr - rptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr[AW-1:0]];
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/pe_link_port.sv
// Host-side partner of a PE stream slot: PE reset sequencing, TX/RX FIFO bridging.
// Optional beat counters tx_words/rx_words when PE_LINK_PORT_CNT_EN is defined.
module pe_link_port
    import pe_link_pkg::*;
#(
    parameter int unsigned FIFO_AW       = 4,
    parameter int unsigned BP_MARGIN     = 4,
    parameter int unsigned PE_RST_CYCLES = 16
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    output logic        pe_rst,
    input  logic        soft_rst,
    output logic        busy,
    output logic        rx_ovf,
`ifdef PE_LINK_PORT_CNT_EN
    output logic [31:0] tx_words,
    output logic [31:0] rx_words,
`endif
    pe_link_if.slave    lnk
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = (PE_RST_CYCLES > 4) ? $clog2(PE_RST_CYCLES) : 2;

    state_e             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               pe_rst_d, busy_d;
    logic               run;
    logic               flush;
    logic               tx_push, tx_pop, tx_full, tx_empty;
    logic               rx_push, rx_pop, rx_full, rx_empty;
    logic               ovf_evt;
    word_t              tx_head;
    logic [FIFO_AW:0]   tx_level_unused;
    logic [FIFO_AW:0]   rx_count;
    logic [FIFO_AW:0]   rx_free;

    assign run   = (state == RUN);
    assign flush = soft_rst | (state == PERST);

    assign lnk.tx_ready = run & ~tx_full;
    assign lnk.rx_valid = run & ~rx_empty;
    assign tx_push      = lnk.tx_valid & lnk.tx_ready;
    assign tx_pop       = run & ~tx_empty & ~lnk.d_bp & ~soft_rst;
    assign rx_pop       = lnk.rx_valid & lnk.rx_ready;
    assign rx_push      = lnk.q_valid & run & (~rx_full | rx_pop);
    assign ovf_evt      = lnk.q_valid & run & rx_full & ~rx_pop & ~soft_rst;
    assign rx_free      = (FIFO_AW+1)'(DEPTH) - rx_count;

    pe_link_fifo #(.W(WORD_W), .AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .rst_n (sys_rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (flush),
        .wdata (lnk.tx_data),
        .rdata (tx_head),
        .count (tx_level_unused),
        .full  (tx_full),
        .empty (tx_empty)
    );

    pe_link_fifo #(.W(WORD_W), .AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .rst_n (sys_rst_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (flush),
        .wdata (lnk.q),
        .rdata (lnk.rx_data),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // State register; pe_rst/busy are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state  <= PERST;
            cnt    <= '0;
            pe_rst <= 1'b1;
            busy   <= 1'b1;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            pe_rst <= pe_rst_d;
            busy   <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            PERST: begin
                if (soft_rst) begin
                    cnt_d = '0;
                end else if (cnt == CNT_W'(PE_RST_CYCLES - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (soft_rst) begin
                    state_d = PERST;
                    cnt_d   = '0;
                end else if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (soft_rst) begin
                    state_d = PERST;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = PERST;
                cnt_d   = '0;
            end
        endcase
        pe_rst_d = (state_d == PERST);
        busy_d   = (state_d != RUN);
    end

    // D output stage, Q backpressure and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            lnk.d       <= '0;
            lnk.d_valid <= 1'b0;
            lnk.q_bp    <= 1'b1;
            rx_ovf      <= 1'b0;
        end else begin
            lnk.d_valid <= tx_pop;
            if (tx_pop) lnk.d <= tx_head;
            lnk.q_bp    <= ~run | soft_rst | (rx_free <= (FIFO_AW+1)'(BP_MARGIN));
            if (soft_rst)     rx_ovf <= 1'b0;
            else if (ovf_evt) rx_ovf <= 1'b1;
        end
    end

`ifdef PE_LINK_PORT_CNT_EN
    always_ff @(posedge clk) begin
        if (!sys_rst_n || soft_rst) begin
            tx_words <= '0;
            rx_words <= '0;
        end else begin
            tx_words <= tx_words + 32'(lnk.d_valid);
            rx_words <= rx_words + 32'(rx_push);
        end
    end
`endif

endmodule

// File: tb/tb_pe_link_port.sv
// Self-checking bench for pe_link_port: directed steps plus random traffic vs a queue model.
module tb_pe_link_port;
    import pe_link_pkg::*;

    localparam int DEPTH   = 16;
    localparam int MARGIN  = 4;
    localparam int RSTC    = 16;
    localparam int RUN_AGE = 18;

    logic clk = 1'b0;
    logic sys_rst_n;
    logic pe_rst;
    logic soft_rst;
    logic busy;
    logic rx_ovf;
`ifdef PE_LINK_PORT_CNT_EN
    logic [31:0] tx_words;
    logic [31:0] rx_words;
`endif

    pe_link_if lnk ();

    pe_link_port dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .pe_rst    (pe_rst),
        .soft_rst  (soft_rst),
        .busy      (busy),
        .rx_ovf    (rx_ovf),
`ifdef PE_LINK_PORT_CNT_EN
        .tx_words  (tx_words),
        .rx_words  (rx_words),
`endif
        .lnk       (lnk)
    );

    always #5 clk = ~clk;

    // Reference model: age since (soft) reset decides the phase; queues hold FIFO contents.
    word_t       txf[$];
    word_t       rxf[$];
    int          m_age;
    bit          m_dv, m_qbp, m_qbp_known, m_ovf;
    word_t       m_d;
    int unsigned m_txw, m_rxw;
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic model_edge();
        bit run, rx_take;
        int txn, rxn;
        run = (m_age >= RUN_AGE);
        if (!sys_rst_n) begin
            txf.delete(); rxf.delete();
            m_age = 0; m_dv = 0; m_d = '0; m_qbp = 1; m_qbp_known = 1; m_ovf = 0;
            m_txw = 0; m_rxw = 0;
            return;
        end
        if (soft_rst) begin
            txf.delete(); rxf.delete();
            m_age = 0; m_dv = 0; m_qbp_known = 0; m_ovf = 0;
            m_txw = 0; m_rxw = 0;
            return;
        end
        m_txw += 32'(m_dv);
        txn = txf.size();
        rxn = rxf.size();
        m_qbp = !run || ((DEPTH - rxn) <= MARGIN);
        m_qbp_known = 1;
        if (run && txn > 0 && !lnk.d_bp) begin
            m_dv = 1;
            m_d  = txf.pop_front();
        end else begin
            m_dv = 0;
        end
        if (lnk.tx_valid && run && txn < DEPTH) txf.push_back(lnk.tx_data);
        rx_take = run && rxn > 0 && lnk.rx_ready;
        if (rx_take) void'(rxf.pop_front());
        if (lnk.q_valid && run) begin
            if (rxn < DEPTH || rx_take) begin
                rxf.push_back(lnk.q);
                m_rxw++;
            end else begin
                m_ovf = 1;
            end
        end
        if (m_age < 1000) m_age++;
    endtask

    task automatic check_all();
        bit run;
        run = (m_age >= RUN_AGE);
        chk("pe_rst",   pe_rst,       m_age < RSTC);
        chk("busy",     busy,         !run);
        chk("d_valid",  lnk.d_valid,  m_dv);
        chk("d",        lnk.d,        m_d);
        if (m_qbp_known) chk("q_bp", lnk.q_bp, m_qbp);
        chk("rx_ovf",   rx_ovf,       m_ovf);
        chk("tx_ready", lnk.tx_ready, run && txf.size() < DEPTH);
        chk("rx_valid", lnk.rx_valid, run && rxf.size() > 0);
        if (run && rxf.size() > 0) chk("rx_data", lnk.rx_data, rxf[0]);
`ifdef PE_LINK_PORT_CNT_EN
        chk("tx_words", tx_words, 64'(m_txw));
        chk("rx_words", rx_words, 64'(m_rxw));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_all();
    endtask

    function automatic word_t rnd_word();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        int n, m, drive_cyc, first_dv, bp_beats;
        bit bp_on;
        sys_rst_n = 1'b0; soft_rst = 1'b0;
        lnk.tx_valid = 1'b0; lnk.tx_data = '0; lnk.d_bp = 1'b0;
        lnk.q = '0; lnk.q_valid = 1'b0; lnk.rx_ready = 1'b0;
        repeat (3) tick();
        sys_rst_n = 1'b1;

        // Reset release: PE_RST length and BUSY fall time.
        n = 0;
        while (pe_rst === 1'b1 && n < 40) begin n++; tick(); end
        chk("pe_rst_len", 64'(n), 64'(16));
        m = n;
        while (busy === 1'b1 && m < 60) begin m++; tick(); end
        chk("busy_fall", 64'(m), 64'(18));

        // Push 1..5 with no backpressure; first beat two cycles after drive.
        drive_cyc = cyc; first_dv = -1;
        for (int k = 1; k <= 5; k++) begin
            lnk.tx_valid = 1'b1; lnk.tx_data = word_t'(k);
            tick();
            if (lnk.d_valid && first_dv < 0) first_dv = cyc;
        end
        lnk.tx_valid = 1'b0;
        repeat (6) begin
            tick();
            if (lnk.d_valid && first_dv < 0) first_dv = cyc;
        end
        chk("tx_latency", 64'(first_dv - drive_cyc), 64'(2));

        // Burst of 10 with D_BP raised mid-burst.
        bp_on = 0; bp_beats = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 6) begin lnk.d_bp = 1'b1; bp_on = 1; end
            lnk.tx_valid = 1'b1; lnk.tx_data = rnd_word();
            tick();
            if (bp_on && lnk.d_valid) bp_beats++;
        end
        lnk.tx_valid = 1'b0;
        repeat (5) begin tick(); if (lnk.d_valid) bp_beats++; end
        chk("bp_beats_le1", 64'(bp_beats <= 1), 64'(1));
        lnk.d_bp = 1'b0;
        n = 0;
        while ((txf.size() > 0 || lnk.d_valid) && n < 40) begin n++; tick(); end
        chk("tx_drain", 64'(txf.size()), 64'(0));

        // Fill RX, then push+pop on full, then overflow, then drain in order.
        lnk.q_valid = 1'b1; lnk.rx_ready = 1'b0;
        repeat (16) begin lnk.q = rnd_word(); tick(); end
        chk("rx_full_qbp", lnk.q_bp, 1'b1);
        lnk.rx_ready = 1'b1;
        repeat (4) begin lnk.q = rnd_word(); tick(); end
        chk("rx_full_pushpop_ovf", rx_ovf, 1'b0);
        lnk.rx_ready = 1'b0; lnk.q = rnd_word();
        tick();
        chk("rx_ovf_set", rx_ovf, 1'b1);
        lnk.q_valid = 1'b0; lnk.rx_ready = 1'b1;
        repeat (18) tick();
        chk("rx_drained", lnk.rx_valid, 1'b0);
        lnk.rx_ready = 1'b0;

        // SOFT_RST with 8 words in each FIFO.
        lnk.d_bp = 1'b1;
        for (int k = 0; k < 8; k++) begin
            lnk.tx_valid = 1'b1; lnk.tx_data = rnd_word();
            lnk.q_valid = 1'b1;  lnk.q = rnd_word();
            tick();
        end
        lnk.tx_valid = 1'b0; lnk.q_valid = 1'b0;
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("soft_ovf_clr", rx_ovf, 1'b0);
`ifdef PE_LINK_PORT_CNT_EN
        chk("soft_tx_words", tx_words, 32'd0);
        chk("soft_rx_words", rx_words, 32'd0);
`endif
        n = 0;
        while (pe_rst === 1'b1 && n < 40) begin n++; tick(); end
        chk("soft_pe_rst_len", 64'(n), 64'(16));
        lnk.d_bp = 1'b0;
        m = 0;
        while (busy === 1'b1 && m < 40) begin m++; tick(); end
        repeat (3) tick();
        chk("soft_rx_empty", lnk.rx_valid, 1'b0);
        chk("soft_tx_empty", lnk.d_valid, 1'b0);

        // Random traffic on all handshakes with rare soft resets.
        for (int k = 0; k < 600; k++) begin
            lnk.tx_valid = 1'($urandom_range(0, 1));
            lnk.tx_data  = rnd_word();
            lnk.d_bp     = ($urandom_range(0, 3) == 0);
            lnk.q_valid  = 1'($urandom_range(0, 1));
            lnk.q        = rnd_word();
            lnk.rx_ready = ($urandom_range(0, 2) != 0);
            soft_rst     = ($urandom_range(0, 249) == 0);
            tick();
        end
        soft_rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
